usb_dev_line_rx: RTL

- Device-side DP/DM line receiver. It is the far end of the host's DP/DM writer.
- It samples the differential pair once per clock and decodes line states J, K, SE0 and SE1.
- It validates the NRZI SYNC pattern, strips it, and streams the packet bits to the device's NRZI-decode/unstuff pipeline.
- It checks the EOP (two SE0 then J) and reports packet start, completion, bit count and framing errors.

---
 rtl/usb_dev_line_rx.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/usb_dev_line_rx.sv
`default_nettype none
// ============================================================================
// Module      : usb_dev_line_rx
// Description : Device-side DP/DM line receiver. Decodes J/K/SE0/SE1 once per
//               clock, validates and strips the NRZI SYNC, streams packet line
//               bits, checks the EOP and reports start/done/error status.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_dev_line_rx #(
  parameter logic [6:0] MAX_BITS = 7'd92,
  parameter logic [3:0] IDLE_LEN = 4'd8
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       dp,
  input  logic       dm,
  input  logic       rx_en,
  output logic       bstr,
  output logic       bstr_valid,
  output logic       pkt_start,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic [6:0] bit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_DATA = 3'd2,
    S_EOP1 = 3'd3,
    S_EOP2 = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Expected dp per SYNC index (bit i = index i): K J K J K J K K
  localparam logic [7:0] c_SYNC_PAT    = 8'b0010_1010;
  localparam logic [1:0] c_ERR_SYNC    = 2'd0;
  localparam logic [1:0] c_ERR_LINE    = 2'd1;
  localparam logic [1:0] c_ERR_LONG    = 2'd2;
  localparam logic [1:0] c_ERR_SHORT   = 2'd3;
  localparam logic [6:0] c_DATA_MAX    = MAX_BITS - 7'd8;
  localparam logic [6:0] c_MIN_BITS    = 7'd8;

  state_t     r_state;
  logic [2:0] r_sync_idx;
  logic [3:0] r_idle_cnt;
  logic       r_bstr;
  logic       r_bstr_valid;
  logic       r_pkt_start;
  logic       r_pkt_done;
  logic       r_pkt_err;
  logic [1:0] r_err_code;
  logic [6:0] r_bit_cnt;

  state_t     w_state_nxt;
  logic [2:0] w_sync_idx_nxt;
  logic [3:0] w_idle_cnt_nxt;
  logic       w_bstr_nxt;
  logic       w_bstr_valid_nxt;
  logic       w_pkt_start_nxt;
  logic       w_pkt_done_nxt;
  logic       w_pkt_err_nxt;
  logic [1:0] w_err_code_nxt;
  logic [6:0] w_bit_cnt_nxt;

  logic       w_is_j;
  logic       w_is_k;
  logic       w_is_se0;
  logic       w_is_jk;

  assign w_is_j   =  dp & ~dm;
  assign w_is_k   = ~dp &  dm;
  assign w_is_se0 = ~dp & ~dm;
  assign w_is_jk  = w_is_j | w_is_k;

  // Next-state and next-output decode for the line receiver
  always_comb begin
    w_state_nxt      = r_state;
    w_sync_idx_nxt   = r_sync_idx;
    w_idle_cnt_nxt   = r_idle_cnt;
    w_bstr_nxt       = r_bstr;
    w_bstr_valid_nxt = 1'b0;
    w_pkt_start_nxt  = 1'b0;
    w_pkt_done_nxt   = 1'b0;
    w_pkt_err_nxt    = 1'b0;
    w_err_code_nxt   = r_err_code;
    w_bit_cnt_nxt    = r_bit_cnt;

    if (!rx_en) begin
      // Reception disabled: park in IDLE with all status cleared, no pulses
      w_state_nxt    = S_IDLE;
      w_sync_idx_nxt = 3'd0;
      w_idle_cnt_nxt = 4'd0;
      w_bit_cnt_nxt  = 7'd0;
      w_err_code_nxt = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_k) begin
            w_state_nxt    = S_SYNC;
            w_sync_idx_nxt = 3'd1;
          end
        end

        S_SYNC: begin
          if (w_is_jk && (dp == c_SYNC_PAT[r_sync_idx])) begin
            if (r_sync_idx == 3'd7) begin
              w_state_nxt     = S_DATA;
              w_pkt_start_nxt = 1'b1;
              w_bit_cnt_nxt   = 7'd0;
              w_sync_idx_nxt  = 3'd0;
            end else begin
              w_sync_idx_nxt = r_sync_idx + 3'd1;
            end
          end else begin
            w_state_nxt    = S_ERR;
            w_pkt_err_nxt  = 1'b1;
            w_err_code_nxt = c_ERR_SYNC;
            w_idle_cnt_nxt = 4'd0;
            w_sync_idx_nxt = 3'd0;
          end
        end

        S_DATA: begin
          if (w_is_jk) begin
            // The bit that would exceed the packet limit is dropped, not emitted
            if (r_bit_cnt == c_DATA_MAX) begin
              w_state_nxt    = S_ERR;
              w_pkt_err_nxt  = 1'b1;
              w_err_code_nxt = c_ERR_LONG;
              w_idle_cnt_nxt = 4'd0;
            end else begin
              w_bstr_nxt       = dp;
              w_bstr_valid_nxt = 1'b1;
              w_bit_cnt_nxt    = r_bit_cnt + 7'd1;
            end
          end else if (w_is_se0) begin
            w_state_nxt = S_EOP1;
          end else begin
            w_state_nxt    = S_ERR;
            w_pkt_err_nxt  = 1'b1;
            w_err_code_nxt = c_ERR_LINE;
            w_idle_cnt_nxt = 4'd0;
          end
        end

        S_EOP1: begin
          if (w_is_se0) begin
            w_state_nxt = S_EOP2;
          end else begin
            w_state_nxt    = S_ERR;
            w_pkt_err_nxt  = 1'b1;
            w_err_code_nxt = c_ERR_LINE;
            w_idle_cnt_nxt = 4'd0;
          end
        end

        S_EOP2: begin
          if (w_is_j) begin
            if (r_bit_cnt >= c_MIN_BITS) begin
              w_state_nxt    = S_IDLE;
              w_pkt_done_nxt = 1'b1;
            end else begin
              w_state_nxt    = S_ERR;
              w_pkt_err_nxt  = 1'b1;
              w_err_code_nxt = c_ERR_SHORT;
              w_idle_cnt_nxt = 4'd0;
            end
          end else begin
            w_state_nxt    = S_ERR;
            w_pkt_err_nxt  = 1'b1;
            w_err_code_nxt = c_ERR_LINE;
            w_idle_cnt_nxt = 4'd0;
          end
        end

        S_ERR: begin
          // Only an unbroken run of IDLE_LEN J samples releases the error state
          if (w_is_j) begin
            if ((r_idle_cnt + 4'd1) == IDLE_LEN) begin
              w_state_nxt    = S_IDLE;
              w_idle_cnt_nxt = 4'd0;
            end else begin
              w_idle_cnt_nxt = r_idle_cnt + 4'd1;
            end
          end else begin
            w_idle_cnt_nxt = 4'd0;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_sync_idx   <= 3'd0;
      r_idle_cnt   <= 4'd0;
      r_bstr       <= 1'b0;
      r_bstr_valid <= 1'b0;
      r_pkt_start  <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_err    <= 1'b0;
      r_err_code   <= 2'd0;
      r_bit_cnt    <= 7'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_sync_idx   <= w_sync_idx_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_bstr       <= w_bstr_nxt;
      r_bstr_valid <= w_bstr_valid_nxt;
      r_pkt_start  <= w_pkt_start_nxt;
      r_pkt_done   <= w_pkt_done_nxt;
      r_pkt_err    <= w_pkt_err_nxt;
      r_err_code   <= w_err_code_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
    end
  end

  assign bstr       = r_bstr;
  assign bstr_valid = r_bstr_valid;
  assign pkt_start  = r_pkt_start;
  assign pkt_done   = r_pkt_done;
  assign pkt_err    = r_pkt_err;
  assign err_code   = r_err_code;
  assign bit_cnt    = r_bit_cnt;

endmodule
`default_nettype wire
